// File: rtl/fetch_queue_unit.sv
// ============================================================================
// Module   : fetch_queue_unit
// Summary  : Instruction-fetch stage. Owns the PC and buffers {instr, pc}
//            pairs for decode in a prefetch FIFO. Redirects flush the queue.
//            Optional FETCH_PERF_CNT_EN adds stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_pll_lock,
    output logic [ADDR_WIDTH-1:0]        o_imem_addr,
    output logic                         o_imem_req,
    input  logic [DATA_WIDTH-1:0]        i_imem_rdata,
    input  logic                         i_redirect,
    input  logic [ADDR_WIDTH-1:0]        i_redirect_pc,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_WIDTH-1:0]        o_instr,
    output logic [ADDR_WIDTH-1:0]        o_pc,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                  o_stall_cycles,
    output logic [31:0]                  o_flush_count
`endif
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    typedef enum logic [0:0] {
        ST_WAIT_LOCK = 1'b0,
        ST_RUN       = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [C_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [C_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [C_CNT_W-1:0]      count_q, count_d;

    logic [DATA_WIDTH-1:0]   instr_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_mem_q    [DEPTH];

    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_push;

    assign w_full  = (count_q == C_CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);
    assign w_pop   = ~w_empty & i_ready & ~i_redirect;
    // A full queue still accepts a fetch when the head leaves in the same cycle.
    assign w_push  = (state_q == ST_RUN) & i_pll_lock & ~i_redirect & (~w_full | w_pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LOCK: if (i_pll_lock)  state_d = ST_RUN;
            ST_RUN:       if (!i_pll_lock) state_d = ST_WAIT_LOCK;
            default:      state_d = ST_WAIT_LOCK;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_redirect) begin
            // Targets are word aligned; the low two bits are discarded.
            pc_d     = i_redirect_pc & ~ADDR_WIDTH'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                pc_d     = pc_q + ADDR_WIDTH'(4);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_WAIT_LOCK;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty queue masks the head to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) begin
            instr_mem_q[wr_ptr_q] <= i_imem_rdata;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end

    assign o_imem_addr = pc_q;
    assign o_imem_req  = w_push;
    assign o_valid     = ~w_empty;
    assign o_instr     = w_empty ? '0 : instr_mem_q[rd_ptr_q];
    assign o_pc        = w_empty ? '0 : pc_mem_q[rd_ptr_q];
    assign o_count     = count_q;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;
    logic        w_stall;

    assign w_stall = (state_q == ST_RUN) & w_full & ~w_pop & ~i_redirect;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (w_stall && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
            if (i_redirect && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_flush_count  = flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
// ============================================================================
// Module   : tb_fetch_queue_unit
// Summary  : Randomized bench for fetch_queue_unit with a queue-based
//            reference model and a handshake-driven scoreboard monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue_unit;

    localparam int          DW       = 32;
    localparam int          AW       = 32;
    localparam int          DEPTH    = 4;
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] SCRAMBLE = 32'hA5A5_0000;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic           i_pll_lock;
    logic [AW-1:0]  o_imem_addr;
    logic           o_imem_req;
    logic [DW-1:0]  i_imem_rdata;
    logic           i_redirect;
    logic [AW-1:0]  i_redirect_pc;
    logic           o_valid;
    logic           i_ready;
    logic [DW-1:0]  o_instr;
    logic [AW-1:0]  o_pc;
    logic [CW-1:0]  o_count;
    logic           o_full;
    logic           o_empty;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]    o_stall_cycles;
    logic [31:0]    o_flush_count;
`endif

    always #5 i_clk = ~i_clk;

    // Instruction memory: combinational, content derived from the address.
    assign i_imem_rdata = o_imem_addr ^ SCRAMBLE;

    fetch_queue_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_pll_lock     (i_pll_lock),
        .o_imem_addr    (o_imem_addr),
        .o_imem_req     (o_imem_req),
        .i_imem_rdata   (i_imem_rdata),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_instr        (o_instr),
        .o_pc           (o_pc),
        .o_count        (o_count),
        .o_full         (o_full),
        .o_empty        (o_empty)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_stall_cycles (o_stall_cycles),
        .o_flush_count  (o_flush_count)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Reference model: expected fetch stream plus PC, run flag and occupancy.
    ent_t        sb_q[$];
    logic [31:0] m_pc;
    bit          m_run;
    int          m_count;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit   pop;
        bit   push;
        ent_t e;
        if (!i_rst_n) begin
            m_pc    = RESET_PC;
            m_run   = 1'b0;
            m_count = 0;
            m_stall = '0;
            m_flush = '0;
            sb_q.delete();
        end else begin
            pop  = (m_count != 0) && i_ready && !i_redirect;
            push = m_run && i_pll_lock && !i_redirect && ((m_count < DEPTH) || pop);
            if (m_run && (m_count == DEPTH) && !pop && !i_redirect && (m_stall != 32'hFFFF_FFFF))
                m_stall = m_stall + 1;
            if (i_redirect && (m_flush != 32'hFFFF_FFFF))
                m_flush = m_flush + 1;
            if (i_redirect) begin
                m_count = 0;
                sb_q.delete();
                m_pc = {i_redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) m_count--;
                if (push) begin
                    e.instr = m_pc ^ SCRAMBLE;
                    e.pc    = m_pc;
                    sb_q.push_back(e);
                    m_count++;
                    m_pc = m_pc + 32'd4;
                end
            end
            m_run = i_pll_lock;
        end
    endtask

    task automatic drive(input bit rst_n, input bit rdy, input bit lock,
                         input bit redir, input logic [31:0] tgt);
        i_rst_n       = rst_n;
        i_ready       = rdy;
        i_pll_lock    = lock;
        i_redirect    = redir;
        i_redirect_pc = tgt;
    endtask

    task automatic step(input bit rst_n, input bit rdy, input bit lock,
                        input bit redir, input logic [31:0] tgt);
        @(posedge i_clk);
        model_step();
        #1;
        drive(rst_n, rdy, lock, redir, tgt);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF0 | (r & 32'hF);
        return 32'h0040_0000 | (r & 32'h000F_FFFF);
    endfunction

    // Monitor: state checks every cycle, scoreboard pop on each accepted head.
    initial begin
        ent_t exp_e;
        bit   m_pop;
        bit   exp_req;
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                check("count", 64'(o_count), 64'(m_count));
                check("empty", 64'(o_empty), 64'(m_count == 0));
                check("full",  64'(o_full),  64'(m_count == DEPTH));
                check("valid", 64'(o_valid), 64'(m_count != 0));
                check("imem_addr", 64'(o_imem_addr), 64'(m_pc));
                m_pop   = (m_count != 0) && i_ready && !i_redirect;
                exp_req = m_run && i_pll_lock && !i_redirect && ((m_count < DEPTH) || m_pop);
                check("imem_req", 64'(o_imem_req), 64'(exp_req));
                if (m_count == 0) begin
                    check("pc_when_empty",    64'(o_pc),    64'd0);
                    check("instr_when_empty", 64'(o_instr), 64'd0);
                end
`ifdef FETCH_PERF_CNT_EN
                check("stall_cycles", 64'(o_stall_cycles), 64'(m_stall));
                check("flush_count",  64'(o_flush_count),  64'(m_flush));
`endif
                if (i_rst_n && o_valid && i_ready && !i_redirect) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_head", 64'(o_pc), 64'hDEAD_0000_0000);
                    end else begin
                        exp_e = sb_q.pop_front();
                        check("head_pc",    64'(o_pc),    64'(exp_e.pc));
                        check("head_instr", 64'(o_instr), 64'(exp_e.instr));
                    end
                end
            end
        end
    end

    // Phase table: length, %ready, %lock, %redirect, %reset.
    localparam int NPH = 9;
    int ph_len   [NPH] = '{20,  12, 30, 300, 200, 200, 200,  10, 300};
    int ph_ready [NPH] = '{100,  0, 100, 60,  30,  90,  50,   0,  50};
    int ph_lock  [NPH] = '{100, 100, 100, 95, 70, 100,  50, 100,  90};
    int ph_redir [NPH] = '{0,    0,  0,   5,  10,  20,   3,   0,   5};
    int ph_rst   [NPH] = '{0,    0,  0,   0,   0,   0,   0,   0,   3};

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        mon_en = 1'b1;
        for (int p = 0; p < NPH; p++) begin
            for (int c = 0; c < ph_len[p]; c++) begin
                step(!($urandom_range(0, 99) < ph_rst[p]),
                     $urandom_range(0, 99) < ph_ready[p],
                     $urandom_range(0, 99) < ph_lock[p],
                     $urandom_range(0, 99) < ph_redir[p],
                     rand_target());
            end
            if (p == 2) begin
                // Back-to-back redirects: only the second target's stream survives.
                step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0200);
                step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0300);
                step(1'b1, 1'b1, 1'b1, 1'b0, '0);
            end
            if (p == 7) begin
                // Reset while the queue is full, with a redirect also pending.
                step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0500);
                step(1'b1, 1'b1, 1'b1, 1'b0, '0);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        @(negedge i_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
